// File: rtl/seq_divider8_pkg.sv
// Shared constants and FSM state type for the sequential divider.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package seq_divider8_pkg;

    // Default operand/result width; the divider iterates once per bit.
    localparam int DIV_WIDTH = 8;

    // Iteration counter width for the default width.
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage : seq_divider8_pkg

// File: rtl/seq_divider8_if.sv
// Operand/result handshake bundle for the sequential divider.
// Latency: n/a (wires only).
// Backpressure: valid/ready on both the operand side and the result side.
//
// Signals:
//   in_valid/in_ready   operand handshake, in_a dividend, in_b divisor
//   out_valid/out_ready result handshake, quo_out, rem_out, div_by_zero
// Modports:
//   master  operand producer / result consumer
//   slave   the divider
interface seq_divider8_if
    import seq_divider8_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] quo_out;
    logic [WIDTH-1:0] rem_out;
    logic             div_by_zero;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, quo_out, rem_out, div_by_zero
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, quo_out, rem_out, div_by_zero
    );

endinterface : seq_divider8_if

// File: rtl/seq_divider8_div_step.sv
// One restoring-division iteration: trial subtract of the divisor from the shifted partial remainder.
// Latency: combinational.
// Backpressure: none (pure datapath).
//
// Ports:
//   i_rem     current partial remainder (always < i_div)
//   i_a_msb   next dividend bit shifted into the remainder
//   i_div     divisor
//   o_rem_nxt remainder after this step (restored on borrow)
//   o_q_bit   quotient bit produced by this step
module seq_divider8_div_step
    import seq_divider8_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic             i_a_msb,
    input  logic [WIDTH-1:0] i_div,
    output logic [WIDTH-1:0] o_rem_nxt,
    output logic             o_q_bit
);

    logic [WIDTH:0] w_trial;
    logic [WIDTH:0] w_diff;
    logic           w_borrow;

    // Subtraction done as add of the inverted divisor with carry-in 1, so the
    // same ripple-add structure as the ALU adder is reused.
    assign w_trial  = {i_rem, i_a_msb};
    assign w_diff   = w_trial + ~{1'b0, i_div} + {{WIDTH{1'b0}}, 1'b1};

    // Because i_rem < i_div, the trial value is below 2*i_div, so the top bit of
    // the difference is set exactly when the subtraction went negative.
    assign w_borrow = w_diff[WIDTH];

    // On borrow the trial value itself is < i_div and fits in WIDTH bits.
    assign o_rem_nxt = w_borrow ? w_trial[WIDTH-1:0] : w_diff[WIDTH-1:0];
    assign o_q_bit   = ~w_borrow;

endmodule : seq_divider8_div_step

// File: rtl/seq_divider8.sv
// Multi-cycle unsigned restoring divider: quo_out = in_a / in_b, rem_out = in_a % in_b.
// Latency: result valid WIDTH+1 cycles after the accept cycle (1 cycle for a zero divisor).
// Backpressure: in_ready low while busy or holding a result; result held stable until out_ready.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; aborts any operation in flight
//   bus    seq_divider8_if slave: operand handshake in, result handshake out
module seq_divider8
    import seq_divider8_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic           clk,
    input  logic           rst_n,
    seq_divider8_if.slave  bus
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    div_state_t       r_state;
    div_state_t       w_state_nxt;
    logic             w_in_ready;
    logic             w_out_valid;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_r;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_rem;
    logic             r_dbz;

    logic [WIDTH-1:0] w_rem_nxt;
    logic             w_q_bit;
    logic [WIDTH-1:0] w_a_nxt;
    logic             w_accept;
    logic             w_last;

    seq_divider8_div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_rem     (r_r),
        .i_a_msb   (r_a[WIDTH-1]),
        .i_div     (r_b),
        .o_rem_nxt (w_rem_nxt),
        .o_q_bit   (w_q_bit)
    );

    // The dividend register doubles as the quotient shift register: each
    // iteration consumes its MSB and appends the new quotient bit at the LSB.
    assign w_a_nxt  = {r_a[WIDTH-2:0], w_q_bit};
    assign w_accept = (r_state == IDLE) && bus.in_valid;
    assign w_last   = (r_state == BUSY) && (r_cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        case (r_state)
            IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_state_nxt = (bus.in_b == '0) ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (r_cnt == '0) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_out_valid = 1'b1;
                // Return to IDLE first, so nothing is accepted in the take cycle.
                if (bus.out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a   <= '0;
            r_b   <= '0;
            r_r   <= '0;
            r_cnt <= '0;
            r_quo <= '0;
            r_rem <= '0;
            r_dbz <= 1'b0;
        end else if (w_accept) begin
            r_a   <= bus.in_a;
            r_b   <= bus.in_b;
            r_r   <= '0;
            r_cnt <= CW'(WIDTH - 1);
            if (bus.in_b == '0) begin
                // Zero divisor skips the iterations and reports directly.
                r_quo <= '1;
                r_rem <= bus.in_a;
                r_dbz <= 1'b1;
            end
        end else if (r_state == BUSY) begin
            r_a <= w_a_nxt;
            r_r <= w_rem_nxt;
            if (w_last) begin
                r_quo <= w_a_nxt;
                r_rem <= w_rem_nxt;
                r_dbz <= 1'b0;
            end else begin
                r_cnt <= r_cnt - CW'(1);
            end
        end
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.out_valid   = w_out_valid;
    assign bus.quo_out     = r_quo;
    assign bus.rem_out     = r_rem;
    assign bus.div_by_zero = r_dbz;

endmodule : seq_divider8
